// File: rtl/uart_aes_frame_loader_pkg.sv
// Shared types and constants for the UART-to-AES frame loader.
// States, error codes and the default command bytes live here.
package uart_aes_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } fsm_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_CMD     = 2'b01,
        ERR_TIMEOUT = 2'b10,
        ERR_OVERRUN = 2'b11
    } err_t;

    localparam logic [7:0] CMD_KEY_DEF = 8'h4B;
    localparam logic [7:0] CMD_PT_DEF  = 8'h50;

endpackage

// File: rtl/uart_aes_frame_loader_gap_timer.sv
// Inter-byte gap counter: counts enabled cycles since the last clear and
// flags the terminal count, TIMEOUT_CYCLES-1.
module uart_gap_timer #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [23:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 24'd0;
        end else if (clear) begin
            count <= 24'd0;
        end else if (enable) begin
            count <= count + 24'd1;
        end
    end

    // The owner leaves the counting state on terminal, so the count never wraps.
    assign terminal = (count == TIMEOUT_CYCLES - 24'd1);

endmodule

// File: rtl/uart_aes_frame_loader.sv
// Parses UART command frames (1 command byte + 16 payload bytes) into one
// 128-bit key or plaintext word offered to the AES core with valid/ready.
module uart_aes_frame_loader
    import uart_aes_pkg::*;
#(
    parameter logic [7:0]  CMD_KEY        = CMD_KEY_DEF,
    parameter logic [7:0]  CMD_PT         = CMD_PT_DEF,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd4096
) (
    input  logic         uart_clock,
    input  logic         uart_reset,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic [127:0] data_out,
    output logic         data_is_key,
    output logic         data_valid,
    input  logic         data_ready,
    output logic         err_pulse,
    output logic [1:0]   err_code,
    output logic         busy
);

    // Handshake: data_valid rises once a full frame is held and stays high,
    // with data_out/data_is_key stable, until the cycle where data_ready is
    // also high; the word transfers on that clock edge.

    fsm_t       state;
    err_t       err_q;
    logic       rx_valid_d;
    logic       accept;
    logic [3:0] byte_cnt;
    logic       gap_term;

    always_ff @(posedge uart_clock or negedge uart_reset) begin
        if (!uart_reset) begin
            rx_valid_d <= 1'b0;
        end else begin
            rx_valid_d <= rx_valid;
        end
    end

    // rx_valid is a level; only its rising edge counts as a new byte.
    assign accept = rx_valid & ~rx_valid_d;

    uart_gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk      (uart_clock),
        .rst_n    (uart_reset),
        .clear    (accept | (state != COLLECT)),
        .enable   (state == COLLECT),
        .terminal (gap_term)
    );

    always_ff @(posedge uart_clock or negedge uart_reset) begin
        if (!uart_reset) begin
            state       <= IDLE;
            data_out    <= 128'd0;
            data_is_key <= 1'b0;
            data_valid  <= 1'b0;
            err_pulse   <= 1'b0;
            err_q       <= ERR_NONE;
            busy        <= 1'b0;
            byte_cnt    <= 4'd0;
        end else begin
            err_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (rx_data == CMD_KEY || rx_data == CMD_PT) begin
                            data_is_key <= (rx_data == CMD_KEY);
                            byte_cnt    <= 4'd0;
                            state       <= COLLECT;
                            busy        <= 1'b1;
                        end else begin
                            err_pulse <= 1'b1;
                            err_q     <= ERR_CMD;
                        end
                    end
                end
                COLLECT: begin
                    // An accept in the terminal cycle wins over the timeout.
                    if (accept) begin
                        data_out <= {data_out[119:0], rx_data};
                        byte_cnt <= byte_cnt + 4'd1;
                        if (byte_cnt == 4'd15) begin
                            state      <= HOLD;
                            data_valid <= 1'b1;
                        end
                    end else if (gap_term) begin
                        err_pulse <= 1'b1;
                        err_q     <= ERR_TIMEOUT;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                HOLD: begin
                    if (accept) begin
                        err_pulse <= 1'b1;
                        err_q     <= ERR_OVERRUN;
                    end
                    if (data_ready) begin
                        data_valid <= 1'b0;
                        state      <= IDLE;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    data_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

    assign err_code = err_q;

endmodule

// File: tb/tb_uart_aes_frame_loader.sv
// Self-checking bench for uart_aes_frame_loader: directed frames plus a
// randomized frame mix checked against a byte-level frame model.
module tb_uart_aes_frame_loader;

    localparam int TIMEOUT = 4096;

    logic         uart_clock;
    logic         uart_reset;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic [127:0] data_out;
    logic         data_is_key;
    logic         data_valid;
    logic         data_ready;
    logic         err_pulse;
    logic [1:0]   err_code;
    logic         busy;

    uart_aes_frame_loader #(
        .TIMEOUT_CYCLES(24'(TIMEOUT))
    ) dut (
        .uart_clock  (uart_clock),
        .uart_reset  (uart_reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .data_out    (data_out),
        .data_is_key (data_is_key),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .err_pulse   (err_pulse),
        .err_code    (err_code),
        .busy        (busy)
    );

    // clock / reset
    initial uart_clock = 1'b0;
    always #5 uart_clock = ~uart_clock;

    int cyc = 0;
    always @(posedge uart_clock) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    // scoreboard and frame model
    int n_tests = 0;
    int n_fail  = 0;
    int last_acc = 0;

    logic [128:0] exp_q[$];
    logic [7:0]   m_bytes[$];
    int           m_mode = 0;
    bit           m_key  = 1'b0;
    logic [1:0]   m_code = 2'b00;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_key  = 1'b0;
        m_code = 2'b00;
        m_bytes.delete();
        exp_q.delete();
    endtask

    // m_mode: 0 = waiting for a command, 1 = gathering payload, 2 = word on offer
    task automatic model_byte(input logic [7:0] b, input bit rdy, output bit pulse, output bit hs);
        logic [127:0] w;
        pulse = 1'b0;
        hs    = 1'b0;
        case (m_mode)
            0: begin
                if (b == 8'h4B || b == 8'h50) begin
                    m_mode = 1;
                    m_key  = (b == 8'h4B);
                    m_bytes.delete();
                end else begin
                    pulse  = 1'b1;
                    m_code = 2'b01;
                end
            end
            1: begin
                m_bytes.push_back(b);
                if (m_bytes.size() == 16) begin
                    w = '0;
                    for (int i = 0; i < 16; i++) w[127 - 8*i -: 8] = m_bytes[i];
                    exp_q.push_back({m_key, w});
                    m_mode = 2;
                end
            end
            default: begin
                pulse  = 1'b1;
                m_code = 2'b11;
                if (rdy) begin
                    hs     = 1'b1;
                    m_mode = 0;
                end
            end
        endcase
    endtask

    // driver tasks
    task automatic send_byte(input logic [7:0] b, input int hold, input bit rdy);
        bit pulse;
        bit hs;
        logic [128:0] e;
        @(posedge uart_clock); #1;
        rx_data    = b;
        rx_valid   = 1'b1;
        data_ready = rdy;
        model_byte(b, rdy, pulse, hs);
        @(posedge uart_clock); #1;
        last_acc   = cyc;
        data_ready = 1'b0;
        check("err_pulse", 128'(err_pulse), 128'(pulse));
        check("err_code", 128'(err_code), 128'(m_code));
        check("busy", 128'(busy), 128'(m_mode != 0));
        check("data_valid", 128'(data_valid), 128'(m_mode == 2));
        if (hs || m_mode == 2) begin
            e = exp_q[0];
            check("data_out_held", data_out, e[127:0]);
            check("data_is_key_held", 128'(data_is_key), 128'(e[128]));
        end
        if (hs) void'(exp_q.pop_front());
        if (hold == 1) rx_valid = 1'b0;
        @(posedge uart_clock); #1;
        check("pulse_width", 128'(err_pulse), 128'(0));
        repeat ((hold > 2) ? hold - 2 : 0) @(posedge uart_clock);
        #1;
        rx_valid = 1'b0;
        @(posedge uart_clock); #1;
    endtask

    task automatic take_word(input int delay);
        logic [128:0] e;
        e = exp_q[0];
        for (int i = 0; i < delay; i++) begin
            check("valid_wait", 128'(data_valid), 128'(1));
            check("data_out_wait", data_out, e[127:0]);
            check("is_key_wait", 128'(data_is_key), 128'(e[128]));
            @(posedge uart_clock); #1;
        end
        check("data_out_take", data_out, e[127:0]);
        data_ready = 1'b1;
        @(posedge uart_clock); #1;
        data_ready = 1'b0;
        check("valid_after_hs", 128'(data_valid), 128'(0));
        check("busy_after_hs", 128'(busy), 128'(0));
        void'(exp_q.pop_front());
        m_mode = 0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input int hold, input bit rand_rdy);
        send_byte(cmd, hold, 1'b0);
        for (int i = 0; i < 16; i++)
            send_byte(8'($urandom_range(0, 255)), hold, rand_rdy ? 1'($urandom_range(0, 1)) : 1'b0);
    endtask

    task automatic wait_timeout();
        bit seen_valid;
        bit seen_err;
        int lat;
        seen_valid = 1'b0;
        seen_err   = 1'b0;
        lat        = -1;
        for (int i = 0; i < TIMEOUT + 100 && !seen_err; i++) begin
            @(posedge uart_clock); #1;
            if (data_valid) seen_valid = 1'b1;
            if (err_pulse) begin
                seen_err = 1'b1;
                lat      = cyc - last_acc;
            end
        end
        m_mode = 0;
        m_code = 2'b10;
        check("timeout_latency", 128'(lat), 128'(TIMEOUT));
        check("timeout_code", 128'(err_code), 128'(m_code));
        check("timeout_no_valid", 128'(seen_valid), 128'(0));
        @(posedge uart_clock); #1;
        check("timeout_busy", 128'(busy), 128'(0));
    endtask

    initial begin
        logic [7:0] b;
        uart_reset = 1'b0;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        data_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge uart_clock);
        #1;
        check("rst_data_out", data_out, 128'd0);
        check("rst_valid", 128'(data_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_err_code", 128'(err_code), 128'(0));
        check("rst_err_pulse", 128'(err_pulse), 128'(0));
        @(negedge uart_clock);
        uart_reset = 1'b1;

        // directed key frame 00..0F
        send_byte(8'h4B, 1, 1'b0);
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1, 1'b0);
        check("key_literal", data_out, 128'h000102030405060708090A0B0C0D0E0F);
        check("key_flag", 128'(data_is_key), 128'(1));
        take_word(0);

        // plaintext frame, ready held off for 50 cycles
        send_byte(8'h50, 1, 1'b0);
        for (int i = 0; i < 16; i++) send_byte(8'hAA, 1, 1'b0);
        check("pt_literal", data_out, {16{8'hAA}});
        check("pt_flag", 128'(data_is_key), 128'(0));
        take_word(50);

        // bad command, then a good key frame
        send_byte(8'h41, 1, 1'b0);
        send_frame(8'h4B, 2, 1'b0);
        take_word(2);

        // inter-byte timeout after 5 payload bytes
        send_byte(8'h4B, 1, 1'b0);
        for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)), 1, 1'b0);
        wait_timeout();

        // long valid levels and an overrun byte while holding
        send_frame(8'h50, 200, 1'b0);
        send_byte(8'h5A, 200, 1'b0);
        take_word(3);

        // overrun byte in the handshake cycle itself
        send_frame(8'h4B, 1, 1'b0);
        send_byte(8'h77, 1, 1'b1);

        // reset in the middle of a frame
        send_byte(8'h4B, 1, 1'b0);
        for (int i = 0; i < 8; i++) send_byte(8'($urandom_range(0, 255)), 1, 1'b0);
        #3;
        uart_reset = 1'b0;
        model_reset();
        #1;
        check("mid_rst_data_out", data_out, 128'd0);
        check("mid_rst_valid", 128'(data_valid), 128'(0));
        check("mid_rst_busy", 128'(busy), 128'(0));
        check("mid_rst_key", 128'(data_is_key), 128'(0));
        check("mid_rst_code", 128'(err_code), 128'(0));
        repeat (2) @(posedge uart_clock);
        @(negedge uart_clock);
        uart_reset = 1'b1;
        send_frame(8'h50, 1, 1'b0);
        take_word(1);

        // randomized frame mix
        for (int n = 0; n < 20; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                do b = 8'($urandom_range(0, 255)); while (b == 8'h4B || b == 8'h50);
                send_byte(b, $urandom_range(1, 4), 1'($urandom_range(0, 1)));
            end else begin
                send_frame($urandom_range(0, 1) ? 8'h4B : 8'h50, $urandom_range(1, 4), 1'b1);
                if ($urandom_range(0, 2) == 0)
                    send_byte(8'($urandom_range(0, 255)), $urandom_range(1, 3), 1'($urandom_range(0, 1)));
                if (m_mode == 2) take_word($urandom_range(0, 10));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
